// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Hazard and sequencing control for the five-stage RISC-V pipeline. It keeps
// a shadow scoreboard of the EXE and MEM stages (destination register, write
// enable, load flag) and uses it to:
//   - generate EXE operand forwarding selects,
//   - detect load-use hazards and insert a single bubble,
//   - flush wrong-path instructions when a branch resolves taken in EXE,
//   - hold the pipeline while the multi-cycle mul/div unit is busy, with a
//     timeout that forces release and raises a sticky error flag.
//
// Ports:
//   clk                 clock, all state changes on the rising edge
//   rst_n               asynchronous active-low reset
//   i_id_valid          instruction in ID is valid
//   i_id_rs1/i_id_rs2   source register indices in ID
//   i_id_rs1_used/..2   the corresponding source is actually read
//   i_id_rd             destination register index in ID
//   i_id_reg_write      instruction in ID writes the register file
//   i_id_is_load        instruction in ID writes back memory data
//   i_id_is_muldiv      instruction in ID is a multi-cycle mul/div
//   i_exe_branch_taken  branch in EXE resolved taken
//   i_muldiv_done       mul/div result valid this cycle
//   o_pc_stall          hold the PC
//   o_if_id_stall       hold IF/ID
//   o_if_id_flush       clear IF/ID to a NOP
//   o_id_exe_hold       hold ID/EXE
//   o_id_exe_bubble     load zeroed controls into ID/EXE
//   o_exe_mem_bubble    load zeroed controls into EXE/MEM
//   o_fwd_a_sel/b_sel   00 register file, 01 EXE result, 10 MEM result
//   o_muldiv_start      one-cycle start pulse to the mul/div unit
//   o_muldiv_err        sticky mul/div timeout flag
//   o_stall_cycles      saturating count of cycles with o_pc_stall high
// ---------------------------------------------------------------------------
module hazard_controller #(
    parameter int MULDIV_TIMEOUT = 40,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_id_valid,
    input  logic [4:0]             i_id_rs1,
    input  logic [4:0]             i_id_rs2,
    input  logic                   i_id_rs1_used,
    input  logic                   i_id_rs2_used,
    input  logic [4:0]             i_id_rd,
    input  logic                   i_id_reg_write,
    input  logic                   i_id_is_load,
    input  logic                   i_id_is_muldiv,
    input  logic                   i_exe_branch_taken,
    input  logic                   i_muldiv_done,
    output logic                   o_pc_stall,
    output logic                   o_if_id_stall,
    output logic                   o_if_id_flush,
    output logic                   o_id_exe_hold,
    output logic                   o_id_exe_bubble,
    output logic                   o_exe_mem_bubble,
    output logic [1:0]             o_fwd_a_sel,
    output logic [1:0]             o_fwd_b_sel,
    output logic                   o_muldiv_start,
    output logic                   o_muldiv_err,
    output logic [STALL_CNT_W-1:0] o_stall_cycles
);

    // Busy counter only has to reach MULDIV_TIMEOUT-1.
    localparam int BUSY_W = (MULDIV_TIMEOUT > 1) ? $clog2(MULDIV_TIMEOUT) : 1;
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MULDIV_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_md_start;
    logic                   r_md_err;
    logic [BUSY_W-1:0]      r_busy_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Shadow scoreboard of the EXE and MEM stages.
    logic [4:0] r_exe_rd;
    logic       r_exe_wr;
    logic       r_exe_ld;
    logic [4:0] r_mem_rd;
    logic       r_mem_wr;

    // Per-source match and forwarding; index 0 is rs1, index 1 is rs2.
    logic [1:0][4:0] w_src_rs;
    logic [1:0]      w_src_used;
    logic [1:0]      w_exe_match;
    logic [1:0]      w_mem_match;
    logic [1:0][1:0] w_fwd_sel;

    assign w_src_rs   = {i_id_rs2, i_id_rs1};
    assign w_src_used = {i_id_rs2_used, i_id_rs1_used};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign w_exe_match[gi] = r_exe_wr && (r_exe_rd != 5'd0) &&
                                     w_src_used[gi] && (r_exe_rd == w_src_rs[gi]);
            assign w_mem_match[gi] = r_mem_wr && (r_mem_rd != 5'd0) &&
                                     w_src_used[gi] && (r_mem_rd == w_src_rs[gi]);
            // A load in EXE has no result yet, so it can only be forwarded
            // from MEM (which happens after the load-use bubble).
            assign w_fwd_sel[gi]   = (w_exe_match[gi] && !r_exe_ld) ? 2'b01 :
                                     w_mem_match[gi]                ? 2'b10 : 2'b00;
        end
    endgenerate

    logic w_busy;
    logic w_timeout;
    logic w_md_release;
    logic w_md_hold;
    logic w_branch;
    logic w_load_use;
    logic w_lu_stall;
    logic w_issue_md;
    logic w_pc_stall;

    assign w_busy       = (r_state == ST_MD_BUSY);
    assign w_timeout    = w_busy && !i_muldiv_done && (r_busy_cnt == BUSY_LAST);
    // The timeout cycle behaves exactly like a done cycle.
    assign w_md_release = w_busy && (i_muldiv_done || w_timeout);
    assign w_md_hold    = w_busy && !w_md_release;
    assign w_branch     = !w_busy && i_exe_branch_taken;
    assign w_load_use   = i_id_valid && (|w_exe_match) && r_exe_ld;
    // In MD_BUSY ID is already held, so a load-use needs no action there.
    // A taken branch kills the dependent instruction, so it wins.
    assign w_lu_stall   = !w_busy && w_load_use && !w_branch;
    assign w_issue_md   = !w_busy && i_id_valid && i_id_is_muldiv &&
                          !w_lu_stall && !w_branch;
    assign w_pc_stall   = w_md_hold || w_lu_stall;

    assign o_pc_stall       = w_pc_stall;
    assign o_if_id_stall    = w_pc_stall;
    assign o_if_id_flush    = w_branch;
    assign o_id_exe_hold    = w_md_hold;
    assign o_id_exe_bubble  = w_branch || w_lu_stall;
    assign o_exe_mem_bubble = w_md_hold;
    assign o_fwd_a_sel      = w_fwd_sel[0];
    assign o_fwd_b_sel      = w_fwd_sel[1];
    assign o_muldiv_start   = r_md_start;
    assign o_muldiv_err     = r_md_err;
    assign o_stall_cycles   = r_stall_cnt;

    // Control FSM with registered start pulse and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_md_start <= 1'b0;
            r_md_err   <= 1'b0;
            r_busy_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_issue_md) begin
                        r_state    <= ST_MD_BUSY;
                        r_md_start <= 1'b1;
                        r_busy_cnt <= '0;
                    end else begin
                        r_md_start <= 1'b0;
                    end
                end
                ST_MD_BUSY: begin
                    r_md_start <= 1'b0;
                    if (w_md_release) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_busy_cnt <= r_busy_cnt + BUSY_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_md_start <= 1'b0;
                end
            endcase
            if (w_timeout) begin
                r_md_err <= 1'b1;
            end
        end
    end

    // Scoreboard follows what the ID/EXE and EXE/MEM registers do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe_rd <= 5'd0;
            r_exe_wr <= 1'b0;
            r_exe_ld <= 1'b0;
            r_mem_rd <= 5'd0;
            r_mem_wr <= 1'b0;
        end else if (w_md_hold) begin
            // EXE keeps the mul/div; a bubble drains into MEM.
            r_mem_wr <= 1'b0;
        end else begin
            r_mem_rd <= r_exe_rd;
            r_mem_wr <= r_exe_wr;
            if (w_branch || w_lu_stall) begin
                r_exe_wr <= 1'b0;
                r_exe_ld <= 1'b0;
            end else begin
                r_exe_rd <= i_id_rd;
                r_exe_wr <= i_id_valid && i_id_reg_write;
                r_exe_ld <= i_id_valid && i_id_is_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_pc_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule
